dds_bank: RTL and testbench

- Parametrised multi-voice phase-accumulator bank for the MIDI synth voice engine.
- Holds one ACC_W-bit phase per voice in internal single-clock RAM and accepts a stream of per-voice update requests.
- For each request it performs a read-modify-write with phase-offset, per-voice phase clear and wrap flag, then emits the tagged truncated phase to the waveform lookup stage.
- Self-clears its RAM after reset and on command.

---
 rtl/dds_bank_if.sv | 29 ++
 rtl/dds_bank.sv | 85 ++++++++
 tb/tb_dds_bank.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dds_bank_if.sv
// dds_bank_if: request/result bus of the phase-accumulator bank.
// master drives requests and clear_all; slave (the bank) returns in_ready,
// tagged results (out_valid/out_voice/out_phase/out_wrap) and voice_err.
interface dds_bank_if #(
  parameter int IDX_W = 8,
  parameter int ACC_W = 32,
  parameter int OUT_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_voice;
  logic [ACC_W-1:0] in_delta;
  logic [ACC_W-1:0] in_offset;
  logic             in_clr;
  logic             clear_all;
  logic             out_valid;
  logic [IDX_W-1:0] out_voice;
  logic [OUT_W-1:0] out_phase;
  logic             out_wrap;
  logic             voice_err;
  modport master(
    output in_valid, in_voice, in_delta, in_offset, in_clr, clear_all,
    input  in_ready, out_valid, out_voice, out_phase, out_wrap, voice_err
  );
  modport slave(
    input  in_valid, in_voice, in_delta, in_offset, in_clr, clear_all,
    output in_ready, out_valid, out_voice, out_phase, out_wrap, voice_err
  );
endinterface

// File: rtl/dds_bank.sv
// dds_bank: multi-voice phase-accumulator bank with RAM-held phases.
// Ports: clk, reset_n (async active-low), bus (dds_bank_if.slave).
// Request accepted in cycle T yields a result (or voice_err) in cycle T+2.
module dds_bank #(
  parameter int VOICES = 256,
  parameter int IDX_W  = 8,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 10
) (
  input logic     clk,
  input logic     reset_n,
  dds_bank_if.slave bus
);
  typedef enum logic {INIT, RUN} state_t;
  state_t           state;
  logic [IDX_W:0]   cnt;
  logic [ACC_W-1:0] mem [VOICES];
  logic [ACC_W-1:0] rd_data;
  logic             acc, in_range;
  logic             s1_valid, s1_bad, s1_clr;
  logic [IDX_W-1:0] s1_voice;
  logic [ACC_W-1:0] s1_delta, s1_offset;
  logic             w_valid;
  logic [IDX_W-1:0] w_voice;
  logic [ACC_W-1:0] w_data;
  logic [ACC_W-1:0] old, phase;
  logic [ACC_W:0]   sum;
  assign bus.in_ready = state == RUN && !bus.clear_all;
  assign acc          = bus.in_valid && bus.in_ready;
  assign in_range     = {1'b0, bus.in_voice} < (IDX_W+1)'(VOICES);
  // The RAM read for this op happened on the same edge that wrote the
  // previous op's result, so that result is taken from w_data instead.
  assign old   = s1_clr ? '0 : (w_valid && w_voice == s1_voice) ? w_data : rd_data;
  assign sum   = {1'b0, old} + {1'b0, s1_delta};
  assign phase = sum[ACC_W-1:0] + s1_offset;
  always_ff @(posedge clk) begin
    if (state == INIT) mem[cnt[IDX_W-1:0]] <= '0;
    else if (s1_valid) mem[s1_voice] <= sum[ACC_W-1:0];
    rd_data <= mem[bus.in_voice];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= INIT;
      cnt           <= '0;
      s1_valid      <= 1'b0;
      s1_bad        <= 1'b0;
      s1_clr        <= 1'b0;
      s1_voice      <= '0;
      s1_delta      <= '0;
      s1_offset     <= '0;
      w_valid       <= 1'b0;
      w_voice       <= '0;
      w_data        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_voice <= '0;
      bus.out_phase <= '0;
      bus.out_wrap  <= 1'b0;
      bus.voice_err <= 1'b0;
    end else begin
      s1_valid      <= acc && in_range;
      s1_bad        <= acc && !in_range;
      s1_clr        <= bus.in_clr;
      s1_voice      <= bus.in_voice;
      s1_delta      <= bus.in_delta;
      s1_offset     <= bus.in_offset;
      w_valid       <= s1_valid;
      w_voice       <= s1_voice;
      w_data        <= sum[ACC_W-1:0];
      bus.out_valid <= s1_valid;
      bus.voice_err <= s1_bad;
      if (s1_valid) begin
        bus.out_voice <= s1_voice;
        bus.out_phase <= phase[ACC_W-1 -: OUT_W];
        bus.out_wrap  <= sum[ACC_W];
      end
      if (bus.clear_all) begin
        state <= INIT;
        cnt   <= '0;
      end else if (state == INIT) begin
        cnt   <= cnt == (IDX_W+1)'(VOICES-1) ? '0 : cnt + 1'b1;
        state <= cnt == (IDX_W+1)'(VOICES-1) ? RUN : INIT;
      end
    end
  end
endmodule

// File: tb/tb_dds_bank.sv
// tb_dds_bank: scoreboard bench for dds_bank (256-voice and 100-voice instances).
module tb_dds_bank;
  typedef struct packed {
    logic       err;
    logic [7:0] v;
    logic [9:0] ph;
    logic       w;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;
  dds_bank_if ia();
  dds_bank_if ib();
  dds_bank dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
  dds_bank #(.VOICES(100)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ib));
  exp_t qa[$];
  exp_t qb[$];
  int ntest = 0;
  int nfail = 0;
  logic [31:0] model [256];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic idle();
    ia.in_valid = 0; ia.in_voice = 0; ia.in_delta = 0; ia.in_offset = 0; ia.in_clr = 0; ia.clear_all = 0;
    ib.in_valid = 0; ib.in_voice = 0; ib.in_delta = 0; ib.in_offset = 0; ib.in_clr = 0; ib.clear_all = 0;
  endtask
  task automatic send(input bit b, input bit vld, input int v, input logic [31:0] d, input logic [31:0] off,
                      input bit clr, input bit cl, output bit a);
    if (b) begin
      ib.in_valid = vld; ib.in_voice = v[7:0]; ib.in_delta = d; ib.in_offset = off; ib.in_clr = clr; ib.clear_all = cl;
    end else begin
      ia.in_valid = vld; ia.in_voice = v[7:0]; ia.in_delta = d; ia.in_offset = off; ia.in_clr = clr; ia.clear_all = cl;
    end
    #1;
    a = b ? (ib.in_valid && ib.in_ready) : (ia.in_valid && ia.in_ready);
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic push(input bit b, input exp_t e);
    if (b) qb.push_back(e);
    else qa.push_back(e);
  endtask
  task automatic req(input bit b, input int v, input logic [31:0] d, input logic [31:0] off,
                     input bit clr, input int ep, input bit ew);
    bit a;
    send(b, 1, v, d, off, clr, 0, a);
    chk(b ? "B.accept" : "A.accept", 32'(a), 1);
    if (a) push(b, {1'b0, v[7:0], ep[9:0], ew});
  endtask
  task automatic bad_req(input bit b, input int v, input logic [31:0] d);
    bit a;
    send(b, 1, v, d, 0, 0, 0, a);
    chk(b ? "B.accept_bad" : "A.accept_bad", 32'(a), 1);
    if (a) push(b, {1'b1, 8'd0, 10'd0, 1'b0});
  endtask
  task automatic wait_ready(input bit b, output int n);
    n = 0;
    while (!(b ? ib.in_ready : ia.in_ready) && n < 2000) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic mon(input bit b);
    logic ov, ve, ow;
    logic [7:0] vo;
    logic [9:0] ph;
    exp_t e;
    ov = b ? ib.out_valid : ia.out_valid;
    ve = b ? ib.voice_err : ia.voice_err;
    ow = b ? ib.out_wrap : ia.out_wrap;
    vo = b ? ib.out_voice : ia.out_voice;
    ph = b ? ib.out_phase : ia.out_phase;
    if (ov || ve) begin
      if ((b ? qb.size() : qa.size()) == 0) begin
        ntest++;
        nfail++;
        $display("FAIL %s unexpected: valid %0b err %0b voice %0d phase %0d", b ? "B.result" : "A.result", ov, ve, vo, ph);
      end else begin
        e = b ? qb.pop_front() : qa.pop_front();
        chk(b ? "B.result{err,valid,voice,phase,wrap}" : "A.result{err,valid,voice,phase,wrap}",
            32'({ve, ov, ve ? 8'd0 : vo, ve ? 10'd0 : ph, ve ? 1'b0 : ow}),
            32'({e.err, !e.err, e.v, e.ph, e.w}));
      end
    end
  endtask
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end
  initial begin
    bit a;
    int n, na, nb;
    logic [31:0] old, d, off;
    logic [32:0] sum;
    logic [31:0] ph;
    int v;
    bit clr, cl, vld;
    idle();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("A.reset_outs", 32'({ia.in_ready, ia.out_valid, ia.out_voice, ia.out_phase, ia.out_wrap, ia.voice_err}), 0);
    chk("B.reset_outs", 32'({ib.in_ready, ib.out_valid, ib.out_voice, ib.out_phase, ib.out_wrap, ib.voice_err}), 0);
    reset_n = 1;
    na = 0;
    nb = 0;
    for (int k = 0; k < 1000 && !(ia.in_ready && ib.in_ready); k++) begin
      na += int'(!ia.in_ready);
      nb += int'(!ib.in_ready);
      @(posedge clk);
      #1;
    end
    chk("A.init_cycles", na, 256);
    chk("B.init_cycles", nb, 100);
    req(0, 7, 32'h0040_0000, 0, 0, 1, 0);
    req(0, 3, 32'h4000_0000, 0, 0, 256, 0);
    req(0, 3, 32'h4000_0000, 0, 0, 512, 0);
    req(0, 3, 32'h4000_0000, 0, 0, 768, 0);
    req(0, 3, 32'h4000_0000, 0, 0, 0, 1);
    req(0, 1, 32'h0100_0000, 0, 0, 4, 0);
    req(0, 2, 32'h0200_0000, 0, 0, 8, 0);
    req(0, 1, 32'h0100_0000, 0, 0, 8, 0);
    req(0, 2, 32'h0200_0000, 0, 0, 16, 0);
    req(0, 1, 32'h0100_0000, 0, 1, 4, 0);
    req(0, 2, 32'h0200_0000, 0, 0, 24, 0);
    req(0, 1, 32'h0100_0000, 0, 0, 8, 0);
    req(0, 2, 32'h0200_0000, 0, 0, 32, 0);
    req(0, 5, 32'h1000_0000, 32'hF000_0000, 0, 0, 0);
    req(0, 5, 32'h0000_0000, 0, 0, 64, 0);
    req(0, 9, 32'h0040_0000, 0, 0, 1, 0);
    send(0, 1, 11, 32'h0040_0000, 0, 0, 1, a);
    chk("A.accept_during_clear", 32'(a), 0);
    wait_ready(0, n);
    chk("A.clear_init_cycles", n, 256);
    req(0, 9, 32'h0040_0000, 0, 0, 1, 0);
    req(0, 7, 32'h0000_0000, 0, 0, 0, 0);
    bad_req(1, 120, 32'h0040_0000);
    bad_req(1, 100, 32'h0040_0000);
    req(1, 99, 32'h0040_0000, 0, 0, 1, 0);
    req(1, 20, 32'h0040_0000, 0, 0, 1, 0);
    req(1, 120 - 64, 32'h0080_0000, 0, 0, 2, 0);
    repeat (4) @(posedge clk);
    #1;
    send(0, 0, 0, 0, 0, 0, 1, a);
    wait_ready(0, n);
    for (int k = 0; k < 256; k++) model[k] = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        reset_n = 0;
        qa.delete();
        qb.delete();
        for (int k = 0; k < 256; k++) model[k] = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
        continue;
      end
      vld = $urandom_range(0, 3) != 0;
      v = int'($urandom_range(0, 7));
      d = $urandom;
      off = $urandom_range(0, 1) != 0 ? $urandom : 32'd0;
      clr = $urandom_range(0, 9) == 0;
      cl = $urandom_range(0, 299) == 0;
      send(0, vld, v, d, off, clr, cl, a);
      if (cl) for (int k = 0; k < 256; k++) model[k] = 0;
      if (a) begin
        old = clr ? 32'd0 : model[v];
        sum = {1'b0, old} + {1'b0, d};
        model[v] = sum[31:0];
        ph = sum[31:0] + off;
        qa.push_back({1'b0, v[7:0], ph[31:22], sum[32]});
      end
    end
    repeat (5) @(posedge clk);
    #1;
    chk("A.queue_empty", qa.size(), 0);
    chk("B.queue_empty", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
